// File: rtl/spider_controller.sv
// Spider position/lifecycle controller: moves, bounces and drops the spider once per
// frame, kills it on a hit, and respawns it after a frame-counted delay.
module spider_controller #(
  parameter int unsigned SCREEN_W       = 640,
  parameter int unsigned SCREEN_H       = 480,
  parameter int unsigned SPRITE         = 64,
  parameter int unsigned STEP_X         = 2,
  parameter int unsigned DROP_Y         = 16,
  parameter int unsigned START_X        = 288,
  parameter int unsigned START_Y        = 32,
  parameter int unsigned RESPAWN_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       hit,
  output logic [9:0] spider_x,
  output logic [9:0] spider_y,
  output logic       spider_alive,
  output logic       killed,
  output logic       dir_right
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned EXT_W = 11;
  localparam int unsigned CNT_W = 8;

  localparam logic [EXT_W-1:0] MAX_X    = EXT_W'(SCREEN_W - SPRITE);
  localparam logic [EXT_W-1:0] MAX_Y    = EXT_W'(SCREEN_H - SPRITE);
  localparam logic [EXT_W-1:0] STEP     = EXT_W'(STEP_X);
  localparam logic [EXT_W-1:0] DROP     = EXT_W'(DROP_Y);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_FRAMES - 1);

  typedef enum logic {
    DEAD  = 1'b0,
    ALIVE = 1'b1
  } state_t;

  state_t             state_q, state_n;
  logic [POS_W-1:0]   x_q, x_n, y_q, y_n;
  logic               dir_q, dir_n;
  logic               killed_q, killed_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               drop;
  logic [EXT_W-1:0]   x_ext, y_ext, x_plus, x_minus, y_plus;

  // Widened arithmetic so edge comparisons never wrap at 10 bits.
  always_comb begin
    x_ext   = {1'b0, x_q};
    y_ext   = {1'b0, y_q};
    x_plus  = x_ext + STEP;
    x_minus = x_ext - STEP;
    y_plus  = y_ext + DROP;
  end

  // Next-state, movement and respawn logic.
  always_comb begin
    state_n  = state_q;
    x_n      = x_q;
    y_n      = y_q;
    dir_n    = dir_q;
    cnt_n    = cnt_q;
    killed_n = 1'b0;
    drop     = 1'b0;

    case (state_q)
      ALIVE: begin
        if (hit) begin
          state_n  = DEAD;
          cnt_n    = '0;
          killed_n = 1'b1;
        end else if (frame_tick && enable) begin
          if (dir_q) begin
            if (x_plus > MAX_X) begin
              x_n   = POS_W'(MAX_X);
              dir_n = 1'b0;
              drop  = 1'b1;
            end else begin
              x_n = POS_W'(x_plus);
            end
          end else begin
            if (x_ext < STEP) begin
              x_n   = '0;
              dir_n = 1'b1;
              drop  = 1'b1;
            end else begin
              x_n = POS_W'(x_minus);
            end
          end
          if (drop) begin
            y_n = (y_plus > MAX_Y) ? POS_W'(START_Y) : POS_W'(y_plus);
          end
        end
      end
      DEAD: begin
        if (frame_tick && enable) begin
          if (cnt_q == CNT_LAST) begin
            state_n = ALIVE;
            x_n     = POS_W'(START_X);
            y_n     = POS_W'(START_Y);
            dir_n   = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_n = ALIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ALIVE;
      x_q      <= POS_W'(START_X);
      y_q      <= POS_W'(START_Y);
      dir_q    <= 1'b1;
      killed_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_n;
      x_q      <= x_n;
      y_q      <= y_n;
      dir_q    <= dir_n;
      killed_q <= killed_n;
      cnt_q    <= cnt_n;
    end
  end

  assign spider_x     = x_q;
  assign spider_y     = y_q;
  assign spider_alive = (state_q == ALIVE);
  assign killed       = killed_q;
  assign dir_right    = dir_q;

endmodule
